// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture block.
// Holds the 640x480@60 timing constants, coordinate/counter widths and the
// capture FSM state type. Nothing in here generates logic on its own.
package vga_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // Vertical timing, in lines.
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Datapath widths.
    localparam int X_W    = 10;   // column, saturates at 1023
    localparam int Y_W    = 9;    // row, saturates at 511
    localparam int RGB_W  = 24;
    localparam int HCNT_W = 12;   // hsync period counter, saturates at 4095
    localparam int FCNT_W = 16;

    typedef enum logic {
        SEEK    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Input stage for the VGA capture block.
// Registers the raw VGA inputs once, normalises sync polarity so hs/vs are 1
// during the pulse, and flags edges against the previous registered value.
//
// Ports:
//   clock, reset                   pixel clock, synchronous active-high reset
//   vga_hsync/vsync/blank_n/r/g/b  raw VGA stream
//   hs, vs, valid, rgb             registered, polarity-normalised stream
//   hs_rise, vs_rise               sync assert edges
//   valid_fall                     end of an active run (end of line)
module vga_sync_edge
    import vga_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vga_hsync,
    input  logic             vga_vsync,
    input  logic             vga_blank_n,
    input  logic [7:0]       vga_r,
    input  logic [7:0]       vga_g,
    input  logic [7:0]       vga_b,
    output logic             hs,
    output logic             vs,
    output logic             valid,
    output logic [RGB_W-1:0] rgb,
    output logic             hs_rise,
    output logic             vs_rise,
    output logic             valid_fall
);

    logic hs_d;
    logic vs_d;
    logic valid_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            hs      <= 1'b0;
            vs      <= 1'b0;
            valid   <= 1'b0;
            rgb     <= '0;
            hs_d    <= 1'b0;
            vs_d    <= 1'b0;
            valid_d <= 1'b0;
        end else begin
            hs      <= SYNC_ACTIVE_LOW ? ~vga_hsync : vga_hsync;
            vs      <= SYNC_ACTIVE_LOW ? ~vga_vsync : vga_vsync;
            valid   <= vga_blank_n;
            rgb     <= {vga_r, vga_g, vga_b};
            hs_d    <= hs;
            vs_d    <= vs;
            valid_d <= valid;
        end
    end

    assign hs_rise    = hs & ~hs_d;
    assign vs_rise    = vs & ~vs_d;
    assign valid_fall = ~valid & valid_d;

endmodule

// File: rtl/vga_capture.sv
// VGA stream capture: recovers pixel coordinates from a VGA stream, issues
// framebuffer writes and checks line/frame/hsync timing, reporting lock.
//
// Ports:
//   clock, reset               pixel clock, synchronous active-high reset
//   vga_*                      incoming VGA stream
//   wr_en/wr_x/wr_y/wr_data    framebuffer write request, {r,g,b}
//   frame_start                pulse on every vsync assert edge
//   line_err/frame_err/hsync_err  one-cycle timing error pulses
//   locked                     LOCK_FRAMES consecutive clean frames seen
//   frame_count                completed frames, wraps
//
// state   | meaning
// SEEK    | waiting for a vsync assert edge; no writes, no error pulses
// CAPTURE | tracking col/row, writing active pixels, checking timing
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_hsync,
    input  logic              vga_vsync,
    input  logic              vga_blank_n,
    input  logic [7:0]        vga_r,
    input  logic [7:0]        vga_g,
    input  logic [7:0]        vga_b,
    output logic              wr_en,
    output logic [X_W-1:0]    wr_x,
    output logic [Y_W-1:0]    wr_y,
    output logic [RGB_W-1:0]  wr_data,
    output logic              frame_start,
    output logic              line_err,
    output logic              frame_err,
    output logic              hsync_err,
    output logic              locked,
    output logic [FCNT_W-1:0] frame_count
);

    localparam logic [X_W-1:0]    H_ACT_X  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    V_ACT_Y  = Y_W'(V_ACTIVE);
    localparam logic [HCNT_W-1:0] H_TOT_C  = HCNT_W'(H_TOTAL);
    localparam int                GOOD_W   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);

    logic             hs;
    logic             vs;
    logic             valid;
    logic [RGB_W-1:0] rgb;
    logic             hs_rise;
    logic             vs_rise;
    logic             valid_fall;

    vga_sync_edge #(
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_sync_edge (
        .clock       (clock),
        .reset       (reset),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hs          (hs),
        .vs          (vs),
        .valid       (valid),
        .rgb         (rgb),
        .hs_rise     (hs_rise),
        .vs_rise     (vs_rise),
        .valid_fall  (valid_fall)
    );

    cap_state_t state_q;
    cap_state_t state_d;

    logic [X_W-1:0]    col_q;
    logic [Y_W-1:0]    row_q;
    logic [HCNT_W-1:0] hs_cnt_q;
    logic              hs_armed_q;
    logic              line_flag_q;   // line_err already pulsed on this line
    logic              frame_bad_q;   // an error occurred during this frame
    logic [GOOD_W-1:0] good_q;

    logic              in_capture;
    logic              sync_viol;
    logic              pix_write;
    logic              line_end;
    logic              frame_end;
    logic              line_err_d;
    logic              frame_err_d;
    logic              hsync_err_d;
    logic              any_err;
    logic [GOOD_W-1:0] good_inc;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEEK:    if (vs_rise) state_d = CAPTURE;
            CAPTURE: state_d = CAPTURE;
            default: state_d = SEEK;
        endcase
    end

    // Per-cycle decisions, registered below
    always_comb begin
        in_capture  = (state_q == CAPTURE);
        // A valid pixel inside a sync pulse is malformed: never written.
        sync_viol   = in_capture && valid && (hs || vs);
        pix_write   = in_capture && valid && !(hs || vs) &&
                      (col_q < H_ACT_X) && (row_q < V_ACT_Y);
        line_end    = in_capture && valid_fall;
        frame_end   = in_capture && vs_rise;
        // Line and frame checks both see the pre-update col/row.
        line_err_d  = in_capture && !line_flag_q &&
                      ((line_end && (col_q != H_ACT_X)) || sync_viol);
        frame_err_d = frame_end && (row_q != V_ACT_Y);
        hsync_err_d = in_capture && hs_rise && hs_armed_q && (hs_cnt_q != H_TOT_C);
        any_err     = line_err_d || frame_err_d || hsync_err_d;
        good_inc    = good_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en       <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            hsync_err   <= 1'b0;
            locked      <= 1'b0;
            frame_count <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hs_cnt_q    <= '0;
            hs_armed_q  <= 1'b0;
            line_flag_q <= 1'b0;
            frame_bad_q <= 1'b0;
            good_q      <= '0;
        end else begin
            wr_en       <= pix_write;
            frame_start <= vs_rise;
            line_err    <= line_err_d;
            frame_err   <= frame_err_d;
            hsync_err   <= hsync_err_d;

            if (pix_write) begin
                wr_x    <= col_q;
                wr_y    <= row_q;
                wr_data <= rgb;
            end

            // Frame end wins over a coincident line end.
            if (!in_capture || frame_end) begin
                col_q <= '0;
                row_q <= '0;
            end else if (line_end) begin
                col_q <= '0;
                if (row_q != '1) row_q <= row_q + 1'b1;
            end else if (valid && (col_q != '1)) begin
                col_q <= col_q + 1'b1;
            end

            // First hs edge in CAPTURE only arms the period check.
            if (!in_capture) begin
                hs_cnt_q   <= '0;
                hs_armed_q <= 1'b0;
            end else if (hs_rise) begin
                hs_cnt_q   <= HCNT_W'(1);
                hs_armed_q <= 1'b1;
            end else if (hs_cnt_q != '1) begin
                hs_cnt_q <= hs_cnt_q + 1'b1;
            end

            if (!in_capture || line_end || frame_end) begin
                line_flag_q <= 1'b0;
            end else if (sync_viol) begin
                line_flag_q <= 1'b1;
            end

            if (frame_end) begin
                frame_count <= frame_count + 1'b1;
                frame_bad_q <= 1'b0;
                if (any_err || frame_bad_q) begin
                    good_q <= '0;
                    locked <= 1'b0;
                end else if (good_q != GOOD_MAX) begin
                    good_q <= good_inc;
                    locked <= (good_inc == GOOD_MAX);
                end else begin
                    locked <= 1'b1;
                end
            end else if (any_err) begin
                good_q      <= '0;
                locked      <= 1'b0;
                frame_bad_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;

    // Reduced timing keeps each frame at 112 clocks.
    localparam int HA    = 8;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int HBP   = 3;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VA    = 4;
    localparam int VFP   = 1;
    localparam int VSW   = 1;
    localparam int VBP   = 1;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int LOCKF = 2;
    localparam int NVEC  = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hsync = 1'b1;
    logic        vga_vsync = 1'b1;
    logic        vga_blank_n = 1'b0;
    logic [7:0]  vga_r = '0;
    logic [7:0]  vga_g = '0;
    logic [7:0]  vga_b = '0;
    logic        wr_en;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [23:0] wr_data;
    logic        frame_start;
    logic        line_err;
    logic        frame_err;
    logic        hsync_err;
    logic        locked;
    logic [15:0] frame_count;

    always #5 clock = ~clock;

    vga_capture #(
        .H_ACTIVE        (HA),
        .V_ACTIVE        (VA),
        .H_TOTAL         (HT),
        .SYNC_ACTIVE_LOW (1'b1),
        .LOCK_FRAMES     (LOCKF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .hsync_err   (hsync_err),
        .locked      (locked),
        .frame_count (frame_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int n_wr, n_le, n_fe, n_he, n_fs, n_bad_data, n_seq;
    int first_x, first_y, last_x, last_y, exp_x, exp_y;
    int first_wr_cyc, first_pix_cyc;
    logic [23:0] cur_color = 24'hFF0000;
    bit          cur_pat   = 1'b0;

    typedef struct {
        int          extra_line;
        int          short_line;
        int          act_lines;
        bit          pat;
        logic [23:0] color;
        int          exp_wr;
        int          exp_le;
        int          exp_fe;
        int          exp_he;
        int          exp_locked;
        int          exp_fc;
        int          exp_last_y;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [23:0] exp_rgb(input int x, input int y);
        logic [7:0] xb;
        logic [7:0] yb;
        logic [7:0] sb;
        xb = 8'(x);
        yb = 8'(y);
        sb = 8'(x + y);
        return cur_pat ? (cur_color ^ {xb, yb, sb}) : cur_color;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        n_wr = 0; n_le = 0; n_fe = 0; n_he = 0; n_fs = 0;
        n_bad_data = 0; n_seq = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        exp_x = 0; exp_y = 0;
        first_wr_cyc = -1; first_pix_cyc = -1;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wr_en) begin
            if (n_wr == 0) begin
                first_x      = int'(wr_x);
                first_y      = int'(wr_y);
                first_wr_cyc = cyc;
            end
            last_x = int'(wr_x);
            last_y = int'(wr_y);
            if (int'(wr_x) != exp_x || int'(wr_y) != exp_y) n_seq++;
            if (wr_data != exp_rgb(int'(wr_x), int'(wr_y))) n_bad_data++;
            n_wr++;
            exp_x++;
            if (exp_x == HA) begin
                exp_x = 0;
                exp_y++;
            end
        end
        if (line_err)    n_le++;
        if (frame_err)   n_fe++;
        if (hsync_err)   n_he++;
        if (frame_start) n_fs++;
    end

    task automatic drive(input bit hs_a, input bit vs_a, input bit val, input logic [23:0] c);
        vga_hsync   = ~hs_a;
        vga_vsync   = ~vs_a;
        vga_blank_n = val;
        {vga_r, vga_g, vga_b} = val ? c : 24'h0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wr_en"},  int'(wr_en), 0);
        check({tag, "_wr_xy"},  int'(wr_x) + int'(wr_y), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_pulses"}, int'({frame_start, line_err, frame_err, hsync_err}), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_fcount"}, int'(frame_count), 0);
        check({tag, "_state_seek"}, int'(dut.state_q), int'(vga_pkg::SEEK));
    endtask

    // One frame: active lines, front porch, vsync line (frame end), back porch.
    task automatic send_frame(input int start_line, input int extra_line, input int short_line,
                              input int act_lines, input int rst_line, input int rst_col);
        for (int ln = start_line; ln < VT; ln++) begin
            int alen;
            int llen;
            bit vs_a;
            vs_a = (ln >= VA + VFP) && (ln < VA + VFP + VSW);
            if (ln < act_lines) alen = (ln == extra_line) ? HA + 1 : HA;
            else                alen = 0;
            llen = (ln == short_line) ? HT - 1 : HT;
            for (int c = 0; c < llen; c++) begin
                bit hs_a;
                bit val;
                hs_a = (c >= HA + HFP) && (c < HA + HFP + HSW);
                val  = (c < alen);
                if (val && first_pix_cyc < 0) first_pix_cyc = cyc;
                if (ln == rst_line && c == rst_col) reset = 1'b1;
                drive(hs_a, vs_a, val, exp_rgb(c, ln));
                if (reset) begin
                    reset = 1'b0;
                    check_reset_state("midrst");
                    clr_stats();
                end
            end
        end
    endtask

    task automatic check_clean_capture(input string tag, input int exp_fc);
        check({tag, "_wr"},        n_wr, HA * VA);
        check({tag, "_first_xy"},  first_x + first_y, 0);
        check({tag, "_last_x"},    last_x, HA - 1);
        check({tag, "_last_y"},    last_y, VA - 1);
        check({tag, "_seq"},       n_seq, 0);
        check({tag, "_errs"},      n_le + n_fe + n_he, 0);
        check({tag, "_fs"},        n_fs, 1);
        check({tag, "_fcount"},    int'(frame_count), exp_fc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //               extra short act pat color      wr  le fe he lk fc lasty
        vecs[0]  = '{-1, -1, VA, 1'b0, 24'hFF0000,  0, 0, 0, 0, 0,  0, -1};
        vecs[1]  = '{-1, -1, VA, 1'b0, 24'hFF0000, 32, 0, 0, 0, 0,  1,  3};
        vecs[2]  = '{-1, -1, VA, 1'b1, 24'h12C3A5, 32, 0, 0, 0, 1,  2,  3};
        vecs[3]  = '{-1, -1, VA, 1'b0, 24'hFF0000, 32, 0, 0, 0, 1,  3,  3};
        vecs[4]  = '{ 1, -1, VA, 1'b0, 24'hFF0000, 32, 1, 0, 0, 0,  4,  3};
        vecs[5]  = '{-1, -1, VA, 1'b1, 24'h0F0F0F, 32, 0, 0, 0, 0,  5,  3};
        vecs[6]  = '{-1, -1, VA, 1'b0, 24'h00FF00, 32, 0, 0, 0, 1,  6,  3};
        vecs[7]  = '{-1,  1, VA, 1'b0, 24'hFF0000, 32, 0, 0, 1, 0,  7,  3};
        vecs[8]  = '{-1, -1, VA, 1'b0, 24'hFF0000, 32, 0, 0, 0, 0,  8,  3};
        vecs[9]  = '{-1, -1,  3, 1'b0, 24'hFF0000, 24, 0, 1, 0, 0,  9,  2};
        vecs[10] = '{-1, -1, VA, 1'b1, 24'hA5A5A5, 32, 0, 0, 0, 0, 10,  3};
        vecs[11] = '{-1, -1, VA, 1'b0, 24'hFF0000, 32, 0, 0, 0, 1, 11,  3};

        clr_stats();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);
        check_reset_state("init");
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cur_color = vecs[i].color;
            cur_pat   = vecs[i].pat;
            clr_stats();
            send_frame(0, vecs[i].extra_line, vecs[i].short_line, vecs[i].act_lines, -1, -1);
            check($sformatf("v%0d_wr", i),        n_wr, vecs[i].exp_wr);
            check($sformatf("v%0d_line_err", i),  n_le, vecs[i].exp_le);
            check($sformatf("v%0d_frame_err", i), n_fe, vecs[i].exp_fe);
            check($sformatf("v%0d_hsync_err", i), n_he, vecs[i].exp_he);
            check($sformatf("v%0d_fs", i),        n_fs, 1);
            check($sformatf("v%0d_locked", i),    int'(locked), vecs[i].exp_locked);
            check($sformatf("v%0d_fcount", i),    int'(frame_count), vecs[i].exp_fc);
            check($sformatf("v%0d_seq", i),       n_seq, 0);
            check($sformatf("v%0d_data", i),      n_bad_data, 0);
            if (vecs[i].exp_wr > 0) begin
                check($sformatf("v%0d_first_xy", i), first_x + first_y, 0);
                check($sformatf("v%0d_last_x", i),   last_x, HA - 1);
                check($sformatf("v%0d_last_y", i),   last_y, vecs[i].exp_last_y);
                check($sformatf("v%0d_latency", i),  first_wr_cyc - first_pix_cyc, 2);
            end
        end

        // Reset pulse mid-frame at pixel (4,2) while locked.
        cur_color = 24'hFF0000;
        cur_pat   = 1'b0;
        clr_stats();
        send_frame(0, -1, -1, VA, 2, 4);
        check("midrst_after_wr", n_wr, 0);
        check("midrst_after_errs", n_le + n_fe + n_he, 0);
        check("midrst_after_fs", n_fs, 1);
        check("midrst_after_fcount", int'(frame_count), 0);
        clr_stats();
        send_frame(0, -1, -1, VA, -1, -1);
        check_clean_capture("midrst_resume", 1);

        // Stream picked up at line 2 of a frame.
        reset = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
        reset = 1'b0;
        clr_stats();
        send_frame(2, -1, -1, VA, -1, -1);
        check("midstart_wr", n_wr, 0);
        check("midstart_errs", n_le + n_fe + n_he, 0);
        check("midstart_fs", n_fs, 1);
        clr_stats();
        send_frame(0, -1, -1, VA, -1, -1);
        check_clean_capture("midstart_resume", 1);
        check("midstart_data", n_bad_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
